vend_sequencer: RTL and testbench
=================================

VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 Parameter RESTOCK_QTY, default 9: per-product inventory after reset or restock (4-bit, 0-15).
REQ-002 Parameter TIMEOUT, default 1000: max cycles to wait for any mechanism ack.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  transaction request; sampled in IDLE only.
REQ-006 prod  in  3  product index, valid 0-4.
REQ-007 price  in  4  product price in coin units.
REQ-008 paid  in  4  money inserted in coin units.
REQ-009 restock  in  1  reload all inventory to RESTOCK_QTY.
REQ-010 motor_req  out  1  dispense-motor request.
REQ-011 motor_ack  in  1  motor handshake acknowledge.
REQ-012 coin_req  out  1  eject-one-coin request.
REQ-013 coin_ack  in  1  coin handshake acknowledge.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 done  out  1  one-cycle pulse at end of every accepted transaction.
REQ-016 err  out  3  result code: 0 ok, 1 bad product, 2 sold out, 3 insufficient funds, 4 motor jam, 5 coin jam.
REQ-017 change_left  out  4  coins still to eject.
REQ-018 empty_mask  out  5  bit i high when inventory[i]==0.

Function
REQ-019 The FSM SHALL have exactly these states: IDLE, CHECK, MOTOR, MOTOR_REL, CHANGE, COIN_REL, DONE.
REQ-020 In IDLE, start=1 SHALL latch prod/price/paid, clear err to 0 and move to CHECK next cycle; start is ignored in all other states.
REQ-021 CHECK SHALL evaluate in priority order: prod>4 -> err=1; inventory[prod]==0 -> err=2; paid<price -> err=3; on any error, change_left=paid and go to CHANGE.
REQ-022 CHECK with no error SHALL set change_left=paid-price (4-bit, no wrap possible) and go to MOTOR.
REQ-023 In MOTOR, motor_req SHALL be 1; on the first cycle motor_ack=1, inventory[prod] SHALL decrement by 1 and the FSM SHALL go to MOTOR_REL.
REQ-024 In MOTOR_REL, motor_req SHALL be 0; the FSM SHALL go to CHANGE once motor_ack=0.
REQ-025 If motor_ack stays 0 for TIMEOUT consecutive cycles in MOTOR, err SHALL become 4, inventory SHALL NOT change, change_left SHALL become paid, and the FSM SHALL go to CHANGE.
REQ-026 In CHANGE with change_left==0 the FSM SHALL go to DONE; otherwise coin_req SHALL be 1 until coin_ack=1, then change_left decrements by 1 and the FSM goes to COIN_REL.
REQ-027 In COIN_REL, coin_req SHALL be 0; the FSM SHALL return to CHANGE once coin_ack=0 (exactly one coin per four-phase handshake).
REQ-028 If coin_ack stays 0 for TIMEOUT cycles in CHANGE, err SHALL become 5, change_left SHALL hold its value, and the FSM SHALL go to DONE.
REQ-029 The timeout counter SHALL clear on every state entry and SHALL be at least ceil(log2(TIMEOUT+1)) bits wide.
REQ-030 DONE SHALL assert done for exactly one cycle and return to IDLE; err SHALL hold until the next accepted start.
REQ-031 restock SHALL be honored only in IDLE, taking effect next cycle; when start and restock coincide, both SHALL be applied and CHECK SHALL see restocked values.
REQ-032 Inventory SHALL never decrement below 0 nor be written outside restock/decrement.
REQ-033 motor_req and coin_req SHALL be registered and never high simultaneously.

Reset
REQ-034 rst=1 SHALL immediately force state IDLE, motor_req=0, coin_req=0, busy=0, done=0, err=0, change_left=0, timeout counter=0, every inventory[i]=RESTOCK_QTY, empty_mask=0.
REQ-035 rst asserted mid-transaction SHALL abort it with no done pulse and no further handshake activity.

Verification
REQ-036 prod=2, price=3, paid=5, acks responding after 2 cycles -> one motor handshake, inventory[2] 9->8, two coin handshakes, done pulse, err=0.
REQ-037 prod=1, price=7, paid=4 -> no motor_req, four coin handshakes, err=3, inventory unchanged.
REQ-038 Dispense prod=0 (price=1, paid=1) nine times, then a tenth time -> empty_mask[0]=1 and tenth returns err=2 with one coin refunded; restock in IDLE -> empty_mask=0.
REQ-039 motor_ack held 0 -> after TIMEOUT cycles err=4, paid refunded as coins, inventory unchanged; coin_ack held 0 -> err=5, change_left frozen, done pulse.
REQ-040 prod=5 -> err=1, paid refunded; start during busy ignored; rst during MOTOR -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/vend_sequencer_if.sv
// Vending sequencer bus: transaction request/result plus the motor and coin
// four-phase handshakes. master = controller side, slave = sequencer.
interface vend_sequencer_if;
    logic       start;
    logic [2:0] prod;
    logic [3:0] price;
    logic [3:0] paid;
    logic       restock;
    logic       motor_req;
    logic       motor_ack;
    logic       coin_req;
    logic       coin_ack;
    logic       busy;
    logic       done;
    logic [2:0] err;
    logic [3:0] change_left;
    logic [4:0] empty_mask;

    modport master (
        output start, prod, price, paid, restock, motor_ack, coin_ack,
        input  motor_req, coin_req, busy, done, err, change_left, empty_mask
    );

    modport slave (
        input  start, prod, price, paid, restock, motor_ack, coin_ack,
        output motor_req, coin_req, busy, done, err, change_left, empty_mask
    );
endinterface

// File: rtl/vend_sequencer.sv
// Vending transaction sequencer: validates a purchase, runs the dispense motor
// handshake, then ejects change one coin per handshake, with per-product stock.
module vend_sequencer #(
    parameter int unsigned RESTOCK_QTY = 9,
    parameter int unsigned TIMEOUT     = 1000
) (
    input logic            clk,
    input logic            rst,
    vend_sequencer_if.slave bus
);
    localparam int unsigned   NPROD  = 5;
    localparam int unsigned   TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]    QTY    = 4'(RESTOCK_QTY);

    typedef enum logic [2:0] {IDLE, CHECK, MOTOR, MOTOR_REL, CHANGE, COIN_REL, DONE} state_t;

    state_t        state;
    logic [2:0]    prod_q;
    logic [3:0]    price_q;
    logic [3:0]    paid_q;
    logic [3:0]    inv [NPROD];
    logic [TW-1:0] tcnt;
    logic [3:0]    sel_inv;
    logic [4:0]    empty;
    logic          motor_q;
    logic          coin_q;
    logic          busy_q;
    logic          done_q;
    logic [2:0]    err_q;
    logic [3:0]    chg;

    always_comb begin
        sel_inv = '0;
        empty   = '0;
        for (int unsigned i = 0; i < NPROD; i++) begin
            if (prod_q == 3'(i)) sel_inv = inv[i];
            empty[i] = (inv[i] == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            prod_q  <= '0;
            price_q <= '0;
            paid_q  <= '0;
            tcnt    <= '0;
            motor_q <= 1'b0;
            coin_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            chg     <= '0;
            for (int unsigned i = 0; i < NPROD; i++) inv[i] <= QTY;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.restock) begin
                        for (int unsigned i = 0; i < NPROD; i++) inv[i] <= QTY;
                    end
                    if (bus.start) begin
                        prod_q  <= bus.prod;
                        price_q <= bus.price;
                        paid_q  <= bus.paid;
                        err_q   <= '0;
                        busy_q  <= 1'b1;
                        tcnt    <= '0;
                        state   <= CHECK;
                    end
                end
                CHECK: begin
                    tcnt <= '0;
                    // Every rejection refunds the full payment through CHANGE.
                    if (prod_q > 3'd4 || sel_inv == '0 || paid_q < price_q) begin
                        if (prod_q > 3'd4)        err_q <= 3'd1;
                        else if (sel_inv == '0)   err_q <= 3'd2;
                        else                      err_q <= 3'd3;
                        chg    <= paid_q;
                        coin_q <= (paid_q != '0);
                        state  <= CHANGE;
                    end else begin
                        chg     <= paid_q - price_q;
                        motor_q <= 1'b1;
                        state   <= MOTOR;
                    end
                end
                MOTOR: begin
                    if (bus.motor_ack) begin
                        for (int unsigned i = 0; i < NPROD; i++) begin
                            if (prod_q == 3'(i) && inv[i] != '0) inv[i] <= inv[i] - 4'd1;
                        end
                        motor_q <= 1'b0;
                        tcnt    <= '0;
                        state   <= MOTOR_REL;
                    end else if (tcnt == T_LAST) begin
                        err_q   <= 3'd4;
                        chg     <= paid_q;
                        motor_q <= 1'b0;
                        coin_q  <= (paid_q != '0);
                        tcnt    <= '0;
                        state   <= CHANGE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                MOTOR_REL: begin
                    if (!bus.motor_ack) begin
                        coin_q <= (chg != '0);
                        tcnt   <= '0;
                        state  <= CHANGE;
                    end
                end
                CHANGE: begin
                    if (chg == '0) begin
                        coin_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else if (bus.coin_ack) begin
                        chg    <= chg - 4'd1;
                        coin_q <= 1'b0;
                        tcnt   <= '0;
                        state  <= COIN_REL;
                    end else if (tcnt == T_LAST) begin
                        err_q  <= 3'd5;
                        coin_q <= 1'b0;
                        done_q <= 1'b1;
                        tcnt   <= '0;
                        state  <= DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                COIN_REL: begin
                    if (!bus.coin_ack) begin
                        coin_q <= (chg != '0);
                        tcnt   <= '0;
                        state  <= CHANGE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    tcnt   <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.motor_req   = motor_q;
    assign bus.coin_req    = coin_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.change_left = chg;
    assign bus.empty_mask  = empty;
endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: ack responders with a two-cycle delay and
// a negedge monitor counting request/done cycles per transaction.
module tb_vend_sequencer;
    localparam int unsigned TO = 16;

    logic clk;
    logic rst;
    vend_sequencer_if bus ();

    vend_sequencer #(.RESTOCK_QTY(9), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    int motor_hs, coin_hs, done_cycles, mreq_cycles, creq_cycles, overlap;
    logic motor_en = 1'b1;
    logic coin_en  = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Motor responder: raise ack two cycles after seeing req, drop when req falls.
    initial begin
        int mcnt;
        mcnt = 0;
        bus.motor_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                bus.motor_ack = 1'b0; mcnt = 0;
            end else if (bus.motor_req && motor_en && !bus.motor_ack) begin
                if (mcnt == 1) begin bus.motor_ack = 1'b1; motor_hs++; mcnt = 0; end
                else mcnt++;
            end else if (!bus.motor_req) begin
                bus.motor_ack = 1'b0; mcnt = 0;
            end
        end
    end

    initial begin
        int ccnt;
        ccnt = 0;
        bus.coin_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                bus.coin_ack = 1'b0; ccnt = 0;
            end else if (bus.coin_req && coin_en && !bus.coin_ack) begin
                if (ccnt == 1) begin bus.coin_ack = 1'b1; coin_hs++; ccnt = 0; end
                else ccnt++;
            end else if (!bus.coin_req) begin
                bus.coin_ack = 1'b0; ccnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.done)      done_cycles++;
            if (bus.motor_req) mreq_cycles++;
            if (bus.coin_req)  creq_cycles++;
            if (bus.motor_req && bus.coin_req) overlap++;
        end
    end

    task automatic clear_counts();
        motor_hs = 0; coin_hs = 0; done_cycles = 0;
        mreq_cycles = 0; creq_cycles = 0; overlap = 0;
    endtask

    task automatic do_txn(input logic [2:0] p, input logic [3:0] pr, input logic [3:0] pd,
                          input logic rs);
        int n;
        @(negedge clk);
        clear_counts();
        bus.start = 1'b1; bus.prod = p; bus.price = pr; bus.paid = pd; bus.restock = rs;
        @(negedge clk);
        bus.start = 1'b0; bus.restock = 1'b0;
        n = 0;
        while (!bus.done && n < 400) begin @(negedge clk); n++; end
        if (n >= 400) begin
            vectors++; miscompares++;
            $display("FAIL done_wait: no done within %0d cycles (prod=%0d)", n, p);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.prod = '0; bus.price = '0; bus.paid = '0; bus.restock = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bus.done); end
        vectors++; if (bus.err !== 3'd0) begin miscompares++; $display("FAIL reset_err: got %0d want 0", bus.err); end
        vectors++; if (bus.change_left !== 4'd0) begin miscompares++; $display("FAIL reset_change: got %0d want 0", bus.change_left); end
        vectors++; if (bus.empty_mask !== 5'b0) begin miscompares++; $display("FAIL reset_empty: got %b want 00000", bus.empty_mask); end
        vectors++; if ({bus.motor_req, bus.coin_req} !== 2'b00) begin miscompares++; $display("FAIL reset_reqs: got %b want 00", {bus.motor_req, bus.coin_req}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dispense();
        do_txn(3'd2, 4'd3, 4'd5, 1'b0);
        vectors++; if (bus.err !== 3'd0) begin miscompares++; $display("FAIL disp_err: got %0d want 0", bus.err); end
        vectors++; if (motor_hs !== 1) begin miscompares++; $display("FAIL disp_motor_hs: got %0d want 1", motor_hs); end
        vectors++; if (coin_hs !== 2) begin miscompares++; $display("FAIL disp_coin_hs: got %0d want 2", coin_hs); end
        vectors++; if (done_cycles !== 1) begin miscompares++; $display("FAIL disp_done_width: got %0d want 1", done_cycles); end
        vectors++; if (bus.change_left !== 4'd0) begin miscompares++; $display("FAIL disp_change: got %0d want 0", bus.change_left); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL disp_busy: got %b want 0", bus.busy); end
        vectors++; if (overlap !== 0) begin miscompares++; $display("FAIL disp_overlap: got %0d want 0", overlap); end
    endtask

    task automatic test_insufficient();
        do_txn(3'd0, 4'd7, 4'd4, 1'b0);
        vectors++; if (bus.err !== 3'd3) begin miscompares++; $display("FAIL funds_err: got %0d want 3", bus.err); end
        vectors++; if (mreq_cycles !== 0) begin miscompares++; $display("FAIL funds_motor: got %0d want 0", mreq_cycles); end
        vectors++; if (coin_hs !== 4) begin miscompares++; $display("FAIL funds_coin_hs: got %0d want 4", coin_hs); end
    endtask

    task automatic test_bad_product();
        do_txn(3'd5, 4'd2, 4'd3, 1'b0);
        vectors++; if (bus.err !== 3'd1) begin miscompares++; $display("FAIL badprod_err: got %0d want 1", bus.err); end
        vectors++; if (coin_hs !== 3) begin miscompares++; $display("FAIL badprod_coin_hs: got %0d want 3", coin_hs); end
        vectors++; if (mreq_cycles !== 0) begin miscompares++; $display("FAIL badprod_motor: got %0d want 0", mreq_cycles); end
    endtask

    task automatic test_motor_timeout();
        motor_en = 1'b0;
        do_txn(3'd0, 4'd1, 4'd2, 1'b0);
        motor_en = 1'b1;
        vectors++; if (bus.err !== 3'd4) begin miscompares++; $display("FAIL mto_err: got %0d want 4", bus.err); end
        vectors++; if (mreq_cycles !== TO) begin miscompares++; $display("FAIL mto_req_cycles: got %0d want %0d", mreq_cycles, TO); end
        vectors++; if (coin_hs !== 2) begin miscompares++; $display("FAIL mto_refund: got %0d want 2", coin_hs); end
    endtask

    task automatic test_coin_timeout();
        coin_en = 1'b0;
        do_txn(3'd3, 4'd1, 4'd3, 1'b0);
        coin_en = 1'b1;
        vectors++; if (bus.err !== 3'd5) begin miscompares++; $display("FAIL cto_err: got %0d want 5", bus.err); end
        vectors++; if (bus.change_left !== 4'd2) begin miscompares++; $display("FAIL cto_frozen: got %0d want 2", bus.change_left); end
        vectors++; if (creq_cycles !== TO) begin miscompares++; $display("FAIL cto_req_cycles: got %0d want %0d", creq_cycles, TO); end
        vectors++; if (done_cycles !== 1) begin miscompares++; $display("FAIL cto_done: got %0d want 1", done_cycles); end
    endtask

    // Product 0 has only seen rejected/timed-out attempts so far: exactly 9 sales must succeed.
    task automatic test_sold_out();
        for (int i = 0; i < 9; i++) begin
            do_txn(3'd0, 4'd1, 4'd1, 1'b0);
            vectors++; if (bus.err !== 3'd0) begin miscompares++; $display("FAIL drain_err[%0d]: got %0d want 0", i, bus.err); end
            vectors++;
            if (bus.empty_mask[0] !== (i == 8)) begin
                miscompares++; $display("FAIL drain_empty[%0d]: got %b want %b", i, bus.empty_mask[0], (i == 8));
            end
        end
        do_txn(3'd0, 4'd1, 4'd1, 1'b0);
        vectors++; if (bus.err !== 3'd2) begin miscompares++; $display("FAIL soldout_err: got %0d want 2", bus.err); end
        vectors++; if (coin_hs !== 1) begin miscompares++; $display("FAIL soldout_refund: got %0d want 1", coin_hs); end
        vectors++; if (mreq_cycles !== 0) begin miscompares++; $display("FAIL soldout_motor: got %0d want 0", mreq_cycles); end
        @(negedge clk); bus.restock = 1'b1;
        @(negedge clk); bus.restock = 1'b0;
        vectors++; if (bus.empty_mask !== 5'b0) begin miscompares++; $display("FAIL restock_empty: got %b want 00000", bus.empty_mask); end
    endtask

    task automatic test_start_with_restock();
        for (int i = 0; i < 9; i++) do_txn(3'd0, 4'd1, 4'd1, 1'b0);
        vectors++; if (bus.empty_mask !== 5'b00001) begin miscompares++; $display("FAIL redrain_empty: got %b want 00001", bus.empty_mask); end
        do_txn(3'd0, 4'd1, 4'd1, 1'b1);
        vectors++; if (bus.err !== 3'd0) begin miscompares++; $display("FAIL start_restock_err: got %0d want 0", bus.err); end
        vectors++; if (motor_hs !== 1) begin miscompares++; $display("FAIL start_restock_motor: got %0d want 1", motor_hs); end
        vectors++; if (bus.empty_mask !== 5'b0) begin miscompares++; $display("FAIL start_restock_empty: got %b want 00000", bus.empty_mask); end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        clear_counts();
        bus.start = 1'b1; bus.prod = 3'd2; bus.price = 4'd1; bus.paid = 4'd1;
        n = 0;
        @(negedge clk);
        while (!bus.done && n < 400) begin @(negedge clk); n++; end
        bus.start = 1'b0;
        if (n >= 400) begin vectors++; miscompares++; $display("FAIL busy_start_wait: no done within %0d cycles", n); end
        repeat (3) @(negedge clk);
        vectors++; if (motor_hs !== 1) begin miscompares++; $display("FAIL busy_start_motor: got %0d want 1", motor_hs); end
        vectors++; if (done_cycles !== 1) begin miscompares++; $display("FAIL busy_start_done: got %0d want 1", done_cycles); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL busy_start_idle: got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        int n;
        motor_en = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.prod = 3'd1; bus.price = 4'd1; bus.paid = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!bus.motor_req && n < 10) begin @(negedge clk); n++; end
        vectors++; if (bus.motor_req !== 1'b1) begin miscompares++; $display("FAIL rstmid_motor_up: got %b want 1", bus.motor_req); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++; if (bus.motor_req !== 1'b0) begin miscompares++; $display("FAIL rstmid_motor: got %b want 0", bus.motor_req); end
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        vectors++; if (bus.change_left !== 4'd0) begin miscompares++; $display("FAIL rstmid_change: got %0d want 0", bus.change_left); end
        @(negedge clk);
        rst = 1'b0;
        motor_en = 1'b1;
        clear_counts();
        repeat (6) @(negedge clk);
        vectors++; if (done_cycles !== 0) begin miscompares++; $display("FAIL rstmid_no_done: got %0d want 0", done_cycles); end
        vectors++; if (mreq_cycles + creq_cycles !== 0) begin miscompares++; $display("FAIL rstmid_no_hs: got %0d want 0", mreq_cycles + creq_cycles); end
        vectors++; if (bus.err !== 3'd0) begin miscompares++; $display("FAIL rstmid_err: got %0d want 0", bus.err); end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_dispense();
        test_insufficient();
        test_bad_product();
        test_motor_timeout();
        test_coin_timeout();
        test_sold_out();
        test_start_with_restock();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
